// File: rtl/async_op_sched.sv
// Round-robin scheduler that shares one 4-phase bundled-data async operator
// (inputs A/B, output O) between two synchronous requesters, with a sticky
// timeout trap on a hung handshake.
module async_op_sched #(
  parameter int unsigned N           = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  output logic         rsp0_valid,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp1_valid,
  output logic [N-1:0] rsp_data,
  output logic         a_r,
  output logic         b_r,
  output logic [N-1:0] a_d,
  output logic [N-1:0] b_d,
  input  logic         a_a,
  input  logic         b_a,
  input  logic         o_r,
  input  logic [N-1:0] o_d,
  output logic         o_a,
  output logic         busy,
  output logic         err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StSetup, StHs, StResp, StErr} state_e;
  typedef enum logic [1:0] {Ip0, Ip1, IpDone} ip_e;
  typedef enum logic [1:0] {Op0, Op1, OpDone} op_e;

  state_e           r_state, w_state_nxt;
  ip_e              r_ip, w_ip_nxt;
  op_e              r_op, w_op_nxt;
  logic             r_got_a, w_got_a_nxt, r_got_b, w_got_b_nxt;
  logic             r_grant, w_grant_nxt, r_last, w_last_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_req, w_req_nxt, r_oa, w_oa_nxt;
  logic [N-1:0]     r_result, w_result_nxt, r_rsp, w_rsp_nxt;
  logic [N-1:0]     r_a_d, w_a_d_nxt, r_b_d, w_b_d_nxt;
  logic [SYNC_STAGES-1:0] r_sync_a, r_sync_b, r_sync_o;
  logic             w_sa, w_sb, w_so, w_take0, w_take1;

  // Bring the async acks/request into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
      r_sync_o <= '0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], a_a};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], b_a};
      r_sync_o <= {r_sync_o[SYNC_STAGES-2:0], o_r};
    end
  end

  assign w_sa = r_sync_a[SYNC_STAGES-1];
  assign w_sb = r_sync_b[SYNC_STAGES-1];
  assign w_so = r_sync_o[SYNC_STAGES-1];

  // Round-robin: on a tie the requester not granted last time wins.
  assign w_take0 = (r_state == StIdle) && req0_valid && (!req1_valid || r_last);
  assign w_take1 = (r_state == StIdle) && req1_valid && (!req0_valid || !r_last);
  assign w_cnt_inc = r_cnt + CW'(1);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_ip     <= Ip0;
      r_op     <= Op0;
      r_got_a  <= 1'b0;
      r_got_b  <= 1'b0;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_oa     <= 1'b0;
      r_result <= '0;
      r_rsp    <= '0;
      r_a_d    <= '0;
      r_b_d    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ip     <= w_ip_nxt;
      r_op     <= w_op_nxt;
      r_got_a  <= w_got_a_nxt;
      r_got_b  <= w_got_b_nxt;
      r_grant  <= w_grant_nxt;
      r_last   <= w_last_nxt;
      r_cnt    <= w_cnt_nxt;
      r_req    <= w_req_nxt;
      r_oa     <= w_oa_nxt;
      r_result <= w_result_nxt;
      r_rsp    <= w_rsp_nxt;
      r_a_d    <= w_a_d_nxt;
      r_b_d    <= w_b_d_nxt;
    end
  end

  // Next-state: arbitration, setup, concurrent input/output handshakes, timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_ip_nxt     = r_ip;
    w_op_nxt     = r_op;
    w_got_a_nxt  = r_got_a;
    w_got_b_nxt  = r_got_b;
    w_grant_nxt  = r_grant;
    w_last_nxt   = r_last;
    w_cnt_nxt    = r_cnt;
    w_req_nxt    = r_req;
    w_oa_nxt     = r_oa;
    w_result_nxt = r_result;
    w_rsp_nxt    = r_rsp;
    w_a_d_nxt    = r_a_d;
    w_b_d_nxt    = r_b_d;
    case (r_state)
      StIdle: begin
        if (w_take0 || w_take1) begin
          w_a_d_nxt   = w_take1 ? req1_a : req0_a;
          w_b_d_nxt   = w_take1 ? req1_b : req0_b;
          w_grant_nxt = w_take1;
          w_last_nxt  = w_take1;
          w_state_nxt = StSetup;
        end
      end
      StSetup: begin
        w_req_nxt   = 1'b1;
        w_cnt_nxt   = '0;
        w_ip_nxt    = Ip0;
        w_op_nxt    = Op0;
        w_got_a_nxt = 1'b0;
        w_got_b_nxt = 1'b0;
        w_state_nxt = StHs;
      end
      StHs: begin
        w_cnt_nxt = w_cnt_inc;
        case (r_ip)
          Ip0: begin
            // Hold an early ack on one channel until the other arrives.
            w_got_a_nxt = r_got_a | w_sa;
            w_got_b_nxt = r_got_b | w_sb;
            if (w_got_a_nxt && w_got_b_nxt) begin
              w_req_nxt = 1'b0;
              w_ip_nxt  = Ip1;
            end
          end
          Ip1:     if (!w_sa && !w_sb) w_ip_nxt = IpDone;
          default: ;
        endcase
        case (r_op)
          Op0: begin
            if (w_so) begin
              w_result_nxt = o_d;
              w_oa_nxt     = 1'b1;
              w_op_nxt     = Op1;
            end
          end
          Op1: begin
            if (!w_so) begin
              w_oa_nxt = 1'b0;
              w_op_nxt = OpDone;
            end
          end
          default: ;
        endcase
        // Timeout wins over a completion landing on the same cycle.
        if (w_cnt_inc == TimeoutVal) begin
          w_req_nxt   = 1'b0;
          w_oa_nxt    = 1'b0;
          w_state_nxt = StErr;
        end else if (w_ip_nxt == IpDone && w_op_nxt == OpDone) begin
          w_rsp_nxt   = w_result_nxt;
          w_state_nxt = StResp;
        end
      end
      StResp: w_state_nxt = StIdle;
      StErr: begin
        w_req_nxt = 1'b0;
        w_oa_nxt  = 1'b0;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign req0_ready = w_take0;
  assign req1_ready = w_take1;
  assign rsp0_valid = (r_state == StResp) && !r_grant;
  assign rsp1_valid = (r_state == StResp) && r_grant;
  assign rsp_data   = r_rsp;
  assign a_r        = r_req;
  assign b_r        = r_req;
  assign a_d        = r_a_d;
  assign b_d        = r_b_d;
  assign o_a        = r_oa;
  assign busy       = (r_state != StIdle);
  assign err        = (r_state == StErr);

endmodule

// File: tb/tb_async_op_sched.sv
// Bench for async_op_sched: directed scenarios plus a randomized phase, driven
// against a behavioural XOR operator with programmable 4-phase ack delays.
module tb_async_op_sched;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (default timeout).
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [N-1:0] rsp_data, a_d, b_d, o_d;
  logic a_r, b_r, o_a, busy, err, a_a, b_a, o_r;

  // Operator model state.
  logic a_a_m = 1'b0, b_a_m = 1'b0, o_r_m = 1'b0;
  logic [N-1:0] o_d_m = '0;
  bit inst = 1'b0;
  bit ovr_en = 1'b0;
  logic [N-1:0] ovr_val = '0;
  int dly_a = 3, dly_b = 3, dly_o = 3;

  // Instant mode: acks and output follow requests as pure levels.
  assign a_a = inst ? a_r : a_a_m;
  assign b_a = inst ? b_r : b_a_m;
  assign o_r = inst ? (a_r & b_r) : o_r_m;
  assign o_d = inst ? (a_d ^ b_d) : o_d_m;

  async_op_sched #(.N(N), .SYNC_STAGES(2), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid),
    .rsp_data(rsp_data), .a_r(a_r), .b_r(b_r), .a_d(a_d), .b_d(b_d),
    .a_a(a_a), .b_a(b_a), .o_r(o_r), .o_d(o_d), .o_a(o_a), .busy(busy), .err(err)
  );

  // Second DUT with a short timeout and an operator that never answers.
  logic t_v0 = 1'b0, t_v1 = 1'b0;
  logic [N-1:0] t_a0 = '0, t_b0 = '0, t_a1 = '0, t_b1 = '0, t_o_d = '0;
  logic t_a_a = 1'b0, t_b_a = 1'b0, t_o_r = 1'b0;
  logic t_rdy0, t_rdy1, t_rsp0, t_rsp1, t_a_r, t_b_r, t_o_a, t_busy, t_err;
  logic [N-1:0] t_rsp_data, t_a_d, t_b_d;

  async_op_sched #(.N(N), .SYNC_STAGES(2), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst),
    .req0_valid(t_v0), .req0_ready(t_rdy0), .req0_a(t_a0), .req0_b(t_b0), .rsp0_valid(t_rsp0),
    .req1_valid(t_v1), .req1_ready(t_rdy1), .req1_a(t_a1), .req1_b(t_b1), .rsp1_valid(t_rsp1),
    .rsp_data(t_rsp_data), .a_r(t_a_r), .b_r(t_b_r), .a_d(t_a_d), .b_d(t_b_d),
    .a_a(t_a_a), .b_a(t_b_a), .o_r(t_o_r), .o_d(t_o_d), .o_a(t_o_a),
    .busy(t_busy), .err(t_err)
  );

  int vec = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Input-channel ack models: follow the request level after a delay.
  initial begin
    int ca = 0;
    forever begin
      @(negedge clk);
      if (rst) begin a_a_m = 1'b0; ca = 0; end
      else if (a_r !== a_a_m) begin
        if (ca >= dly_a) begin a_a_m = a_r; ca = 0; end else ca++;
      end else ca = 0;
    end
  end

  initial begin
    int cb = 0;
    forever begin
      @(negedge clk);
      if (rst) begin b_a_m = 1'b0; cb = 0; end
      else if (b_r !== b_a_m) begin
        if (cb >= dly_b) begin b_a_m = b_r; cb = 0; end else cb++;
      end else cb = 0;
    end
  end

  // Output-channel model: one token per input request pair, 4-phase on O.
  initial begin
    int os = 0;
    int co = 0;
    forever begin
      @(negedge clk);
      if (rst) begin o_r_m = 1'b0; os = 0; co = 0; end
      else begin
        case (os)
          0: if (a_r && b_r) begin
            if (co >= dly_o) begin
              o_d_m = ovr_en ? ovr_val : (a_d ^ b_d);
              o_r_m = 1'b1; os = 1; co = 0;
            end else co++;
          end
          1: if (o_a) begin
            if (co >= dly_o) begin o_r_m = 1'b0; os = 2; co = 0; end else co++;
          end
          default: if (!o_a && !a_r) os = 0;
        endcase
      end
    end
  end

  // One transaction from requester `who`; checks grant, response, ack ordering.
  task automatic run_one(input bit who, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp, input string tag, output int lat);
    bit seen, sawa, sawb, early, prev_ar;
    seen = 0; sawa = 0; sawb = 0; early = 0; prev_ar = 0;
    @(negedge clk);
    if (!who) begin req0_valid = 1; req0_a = a; req0_b = b; end
    else begin req1_valid = 1; req1_a = a; req1_b = b; end
    for (int i = 0; i < 50 && !seen; i++) begin
      #1 seen = who ? req1_ready : req0_ready;
      if (!seen) @(negedge clk);
    end
    chk({tag, "_ready"}, 32'(seen), 32'd1);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    lat = 1;
    #1;
    while (!(rsp0_valid || rsp1_valid) && lat < 400) begin
      if (a_a) sawa = 1;
      if (b_a) sawb = 1;
      if (prev_ar && !a_r && !(sawa && sawb)) early = 1;
      prev_ar = a_r;
      @(negedge clk); #1;
      lat++;
    end
    chk({tag, "_rsp"}, {30'd0, rsp1_valid, rsp0_valid}, who ? 32'd2 : 32'd1);
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp));
    chk({tag, "_ackorder"}, 32'(early), 32'd0);
  endtask

  // No further responses and all handshake outputs idle.
  task automatic quiet(input string tag, input int cycles);
    int extra;
    extra = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk); #1;
      if (rsp0_valid || rsp1_valid) extra++;
    end
    chk({tag, "_extra"}, 32'(extra), 32'd0);
    chk({tag, "_idle"}, {29'd0, a_r, b_r, o_a}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int lat, n, nrsp, owner, issued, done, mout, mown, mlast;
    bit e0, e1, drop0, drop1;
    logic [N-1:0] mexp;
    int grants[$];

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, a_r, b_r, o_a, busy, err},
        32'd0);
    chk("rst_data", {8'd0, rsp_data, a_d, b_d}, 32'd0);
    @(negedge clk); rst = 0;

    // Contention: both valid from reset; grants must alternate starting with 0.
    dly_a = 1; dly_b = 1; dly_o = 1;
    @(negedge clk);
    req0_valid = 1; req0_a = 6'h01; req0_b = 6'h02;
    req1_valid = 1; req1_a = 6'h30; req1_b = 6'h0F;
    nrsp = 0;
    for (int i = 0; i < 400 && nrsp < 4; i++) begin
      #1;
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp0_valid || rsp1_valid) begin
        owner = (nrsp < grants.size()) ? grants[nrsp] : 2;
        chk("cont_owner", {30'd0, rsp1_valid, rsp0_valid}, owner == 1 ? 32'd2 : 32'd1);
        chk("cont_data", 32'(rsp_data), owner == 1 ? 32'h3F : 32'h03);
        nrsp++;
      end
      if (nrsp < 4) @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    chk("cont_nrsp", 32'(nrsp), 32'd4);
    for (int k = 0; k < 4; k++)
      chk("cont_grant", (k < grants.size()) ? 32'(grants[k]) : 32'd9, 32'(k % 2));

    // Single op with 3-cycle ack delays.
    dly_a = 3; dly_b = 3; dly_o = 3;
    run_one(0, 6'h2A, 6'h15, 6'h3F, "single", lat);
    quiet("single", 12);

    // Instant acks: minimum ready-to-response latency.
    inst = 1;
    run_one(1, 6'h0C, 6'h21, 6'h2D, "inst", lat);
    chk("inst_latency", 32'(lat), 32'd8);
    quiet("inst", 4);
    inst = 0;
    repeat (4) @(negedge clk);

    // Output token arrives before any input ack.
    dly_a = 12; dly_b = 12; dly_o = 0; ovr_en = 1; ovr_val = 6'h11;
    run_one(0, 6'h05, 6'h06, 6'h11, "early", lat);
    quiet("early", 16);
    ovr_en = 0;

    // A ack 20 cycles after B ack.
    dly_a = 23; dly_b = 3; dly_o = 2;
    run_one(1, 6'h3C, 6'h0A, 6'h36, "skew", lat);
    quiet("skew", 30);

    // Randomized traffic against the arbitration/response model.
    do_reset();
    mout = 0; mown = 0; mlast = 1; mexp = '0; issued = 0; done = 0;
    drop0 = 0; drop1 = 0;
    for (int cyc = 0; cyc < 6000 && done < 30; cyc++) begin
      @(negedge clk);
      if (drop0 || issued >= 30) req0_valid = 0;
      if (drop1 || issued >= 30) req1_valid = 0;
      drop0 = 0; drop1 = 0;
      if (issued < 30 && !req0_valid && $urandom_range(1, 0) == 1) begin
        req0_valid = 1; req0_a = N'($urandom); req0_b = N'($urandom);
      end
      if (issued < 30 && !req1_valid && $urandom_range(1, 0) == 1) begin
        req1_valid = 1; req1_a = N'($urandom); req1_b = N'($urandom);
      end
      #1;
      e0 = (mout == 0) && req0_valid && (!req1_valid || mlast == 1);
      e1 = (mout == 0) && req1_valid && (!req0_valid || mlast == 0);
      chk("rnd_ready", {30'd0, req1_ready, req0_ready}, {30'd0, e1, e0});
      if (rsp0_valid || rsp1_valid) begin
        chk("rnd_rsp", {30'd0, rsp1_valid, rsp0_valid},
            mout == 0 ? 32'd0 : (mown == 1 ? 32'd2 : 32'd1));
        chk("rnd_data", 32'(rsp_data), 32'(mexp));
        mout = 0; done++;
      end
      if (e0 || e1) begin
        mout = 1; mown = e1 ? 1 : 0; mlast = mown; issued++;
        mexp = e1 ? (req1_a ^ req1_b) : (req0_a ^ req0_b);
        drop0 = e0; drop1 = e1;
        dly_a = $urandom_range(4, 0); dly_b = $urandom_range(4, 0);
        dly_o = $urandom_range(4, 0);
      end
    end
    req0_valid = 0; req1_valid = 0;
    chk("rnd_done", 32'(done), 32'd30);

    // Reset in the middle of the input handshake.
    dly_a = 10; dly_b = 10; dly_o = 10;
    @(negedge clk);
    req1_valid = 1; req1_a = 6'h12; req1_b = 6'h34;
    @(negedge clk);
    req1_valid = 0;
    n = 0;
    #1;
    while (!a_r && n < 20) begin @(negedge clk); #1; n++; end
    chk("mid_ar_up", 32'(a_r), 32'd1);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("mid_rst_outs", {28'd0, a_r, b_r, o_a, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    dly_a = 2; dly_b = 2; dly_o = 2;
    run_one(1, 6'h07, 6'h30, 6'h37, "post_rst", lat);
    quiet("post_rst", 6);

    // Timeout on the short-timeout instance.
    @(negedge clk);
    t_v0 = 1; t_a0 = 6'h2A; t_b0 = 6'h15;
    n = 0;
    #1;
    while (!t_a_r && n < 20) begin @(negedge clk); #1; n++; end
    chk("to_ar_up", 32'(t_a_r), 32'd1);
    n = 0;
    while (!t_err && n < 100) begin @(negedge clk); #1; n++; end
    chk("to_cycles", 32'(n), 32'd16);
    @(negedge clk);
    t_v1 = 1; t_a1 = 6'h01; t_b1 = 6'h02;
    #1;
    chk("to_outs", {27'd0, t_a_r, t_b_r, t_o_a, t_rdy0, t_rdy1}, 32'd0);
    chk("to_flags", {30'd0, t_err, t_busy}, 32'd3);
    repeat (10) @(negedge clk);
    #1;
    chk("to_sticky", {30'd0, t_err, t_rdy0 | t_rdy1}, 32'd2);
    #2 rst = 1;
    #1;
    chk("to_rst", {30'd0, t_err, t_busy}, 32'd0);
    @(negedge clk);
    t_v0 = 0; t_v1 = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk); #1;
    chk("to_idle", {30'd0, t_err, t_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
